mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have the parameter STARVE_LIM, default 3: DMA wait cycles, with CPU priority in force, before DMA is forced a grant.
REQ-002 The block SHALL have the parameter DMA_MAX_BURST, default 4: maximum consecutive DMA grants while cpu_req is high.
REQ-003 The block SHALL have the port Clk  in  1: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have the port reset  in  1: synchronous, active-high reset.
REQ-005 The block SHALL have the ports cpu_req in 1, cpu_wr in 1, cpu_addr in 32, cpu_wdata in 32: the CPU access request, write flag (1 = write), byte address and store data.
REQ-006 The block SHALL have the ports cpu_gnt out 1, cpu_rvalid out 1, cpu_rdata out 32: the CPU grant, read-data valid and read data.
REQ-007 The block SHALL have the ports dma_req, dma_wr, dma_addr, dma_wdata, dma_gnt, dma_rvalid and dma_rdata: the same widths and meanings as the cpu_* ports, for the DMA/loader requester.
REQ-008 The block SHALL have the ports mem_addr out 32, mem_wr out 1, mem_wdata out 32 and mem_rdata in 32: the shared single-port memory (Address, wr, Datain, Dataout); read data is valid one cycle after the address is presented.

Function
REQ-009 The block SHALL hold a two-state FSM {ARB, DMA_BURST}, a wait counter wcnt (0..STARVE_LIM, saturating), a burst counter bcnt (0..DMA_MAX_BURST) and a read-return register {rv_cpu, rv_dma}.
REQ-010 The block SHALL grant combinationally: at most one of cpu_gnt/dma_gnt is high per cycle, a grant is only given to a requester whose req is high, and a request is served in the cycle its grant is high.
REQ-011 In ARB the block SHALL arbitrate as follows:
- only cpu_req: grant CPU.
- only dma_req: grant DMA.
- both high and wcnt < STARVE_LIM: grant CPU.
- both high and wcnt == STARVE_LIM: grant DMA.
REQ-012 In DMA_BURST the block SHALL grant DMA whenever dma_req is high, regardless of cpu_req; otherwise it SHALL grant CPU if cpu_req is high.
REQ-013 The block SHALL transition ARB -> DMA_BURST on any DMA grant issued while cpu_req is high, and SHALL load bcnt with 1 on that edge.
REQ-014 In DMA_BURST, on each DMA grant with cpu_req high, the block SHALL increment bcnt; when the post-increment value equals DMA_MAX_BURST, it SHALL return to ARB with bcnt = 0.
REQ-015 In DMA_BURST, a cycle with dma_req low SHALL return the FSM to ARB with bcnt = 0.
REQ-016 In DMA_BURST, a DMA grant with cpu_req low SHALL keep the FSM in DMA_BURST with bcnt unchanged.
REQ-017 The block SHALL update wcnt as follows:
- +1, saturating at STARVE_LIM, in a cycle with dma_req high and dma_gnt low.
- cleared to 0 when dma_gnt is high or dma_req is low.
REQ-018 The block SHALL drive the memory from the granted requester in the grant cycle: mem_addr, mem_wdata and mem_wr = that requester's addr, wdata and wr.
REQ-019 With no grant, the block SHALL drive mem_addr = cpu_addr, mem_wdata = cpu_wdata and mem_wr = 0.
REQ-020 A read grant (gnt with wr = 0) SHALL set the owner's rv bit on the next edge; cpu_rvalid/dma_rvalid SHALL equal rv_cpu/rv_dma, giving 1-cycle read latency. rv bits SHALL clear on any edge with no read grant for that owner.
REQ-021 The block SHALL drive cpu_rdata and dma_rdata as combinational copies of mem_rdata, meaningful only while the matching rvalid is high.
REQ-022 A write grant SHALL complete at the grant-cycle edge and SHALL produce no rvalid.
REQ-023 Back-to-back grants to either requester SHALL be legal every cycle, giving a throughput of one access per cycle.
REQ-024 A requester that sees its grant low SHALL hold req, wr, addr and wdata stable; the arbiter SHALL NOT latch requests.

Reset
REQ-025 While reset is high, the block SHALL force cpu_gnt = dma_gnt = 0 and mem_wr = 0.
REQ-026 At the first edge with reset high, the block SHALL set FSM = ARB, wcnt = 0, bcnt = 0, rv_cpu = rv_dma = 0.
REQ-027 A read granted in the cycle before reset asserts SHALL produce no rvalid.
REQ-028 No memory write SHALL occur on any edge at which reset is high.
REQ-029 The block SHALL be able to grant in the first cycle after reset deasserts.

Verification
REQ-030 The bench SHALL cover: CPU-only read of 0x40 in cycle t -> cpu_gnt=1 at t, mem_addr=0x40, mem_wr=0; cpu_rvalid=1 at t+1 with cpu_rdata=mem_rdata; dma_gnt never high.
REQ-031 The bench SHALL cover: cpu_req and dma_req both held high from t0 (defaults) -> CPU at t0..t2 (wcnt 1,2,3); DMA at t3..t6 (burst of 4); CPU at t7..t9; DMA again at t10.
REQ-032 The bench SHALL cover: DMA-only writes to 0x100..0x10C with cpu_req low -> dma_gnt=1 every cycle, mem_wr=1 with matching addr/wdata, no rvalid on either port.
REQ-033 The bench SHALL cover: forced DMA grant at t3, with dma_req dropping at t4 while cpu_req stays high -> FSM back to ARB, cpu_gnt=1 at t4, wcnt=0.
REQ-034 The bench SHALL cover: CPU read granted at t, reset high at t+1 -> cpu_rvalid=0 at t+1 and t+2, both grants 0 during reset, FSM=ARB after reset.
REQ-035 The bench SHALL cover: CPU write then CPU read of the same address in consecutive cycles -> cpu_rdata at the read's rvalid cycle equals the written data.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: CPU and DMA requester ports plus the shared memory port.
// slave is the arbiter's view; master is the requesters' and memory's view.
interface mem_arbiter_if;
  logic        cpu_req;
  logic        cpu_wr;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_gnt;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;

  logic        dma_req;
  logic        dma_wr;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic        dma_gnt;
  logic        dma_rvalid;
  logic [31:0] dma_rdata;

  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  dma_req, dma_wr, dma_addr, dma_wdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_addr, mem_wr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output dma_req, dma_wr, dma_addr, dma_wdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_addr, mem_wr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port memory: CPU priority with DMA
// starvation guard and bounded DMA bursts; 1-cycle read return.
module mem_arbiter #(
  parameter int unsigned STARVE_LIM    = 3,
  parameter int unsigned DMA_MAX_BURST = 4
) (
  input  logic          Clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam int unsigned WW = (STARVE_LIM    > 0) ? $clog2(STARVE_LIM + 1)    : 1;
  localparam int unsigned BW = (DMA_MAX_BURST > 0) ? $clog2(DMA_MAX_BURST + 1) : 1;

  typedef enum logic {ARB, DMA_BURST} state_t;

  state_t          state;
  logic [WW-1:0]   wcnt;
  logic [BW-1:0]   bcnt;
  logic            rv_cpu;
  logic            rv_dma;
  logic            cpu_gnt;
  logic            dma_gnt;

  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (!reset) begin
      if (state == DMA_BURST) begin
        if (bus.dma_req)      dma_gnt = 1'b1;
        else if (bus.cpu_req) cpu_gnt = 1'b1;
      end else if (bus.cpu_req && bus.dma_req) begin
        if (wcnt == WW'(STARVE_LIM)) dma_gnt = 1'b1;
        else                         cpu_gnt = 1'b1;
      end else if (bus.cpu_req) begin
        cpu_gnt = 1'b1;
      end else if (bus.dma_req) begin
        dma_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    bus.mem_addr  = bus.cpu_addr;
    bus.mem_wdata = bus.cpu_wdata;
    bus.mem_wr    = 1'b0;
    if (dma_gnt) begin
      bus.mem_addr  = bus.dma_addr;
      bus.mem_wdata = bus.dma_wdata;
      bus.mem_wr    = bus.dma_wr;
    end else if (cpu_gnt) begin
      bus.mem_wr    = bus.cpu_wr;
    end
  end

  assign bus.cpu_gnt   = cpu_gnt;
  assign bus.dma_gnt   = dma_gnt;
  assign bus.cpu_rdata = bus.mem_rdata;
  assign bus.dma_rdata = bus.mem_rdata;
  // Masked during reset so a read granted just before reset never returns.
  assign bus.cpu_rvalid = rv_cpu && !reset;
  assign bus.dma_rvalid = rv_dma && !reset;

  always_ff @(posedge Clk) begin
    if (reset) begin
      state  <= ARB;
      wcnt   <= '0;
      bcnt   <= '0;
      rv_cpu <= 1'b0;
      rv_dma <= 1'b0;
    end else begin
      rv_cpu <= cpu_gnt && !bus.cpu_wr;
      rv_dma <= dma_gnt && !bus.dma_wr;

      if (dma_gnt || !bus.dma_req)     wcnt <= '0;
      else if (wcnt != WW'(STARVE_LIM)) wcnt <= wcnt + WW'(1);

      unique case (state)
        ARB: begin
          if (dma_gnt && bus.cpu_req) begin
            state <= DMA_BURST;
            bcnt  <= BW'(1);
          end
        end
        DMA_BURST: begin
          if (!bus.dma_req) begin
            state <= ARB;
            bcnt  <= '0;
          end else if (bus.cpu_req) begin
            if (bcnt + BW'(1) == BW'(DMA_MAX_BURST)) begin
              state <= ARB;
              bcnt  <= '0;
            end else begin
              bcnt  <= bcnt + BW'(1);
            end
          end
        end
        default: begin
          state <= ARB;
          bcnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then randomized traffic, each cycle
// checked against a behavioural arbitration/memory model.
module tb_mem_arbiter;
  localparam int unsigned STARVE_LIM    = 3;
  localparam int unsigned DMA_MAX_BURST = 4;

  logic Clk = 1'b0;
  logic reset;
  always #5 Clk = ~Clk;

  mem_arbiter_if bus();

  mem_arbiter #(.STARVE_LIM(STARVE_LIM), .DMA_MAX_BURST(DMA_MAX_BURST)) dut (
    .Clk   (Clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Environment memory: synchronous write, read data one cycle after address.
  logic [31:0] mem [256];
  always @(posedge Clk) begin
    if (bus.mem_wr) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr[9:2]];
  end

  int n_cmp = 0;
  int n_mis = 0;

  // Stimulus for the current cycle
  logic        s_rst, s_creq, s_cwr, s_dreq, s_dwr;
  logic [31:0] s_caddr, s_cwd, s_daddr, s_dwd;

  // Reference model state
  int          m_run;   // DMA grants taken in the current contended run (0 = none)
  int          m_wait;  // cycles DMA has been refused
  logic        m_rv_c, m_rv_d, m_ok_c, m_ok_d;
  logic [31:0] m_rd_c, m_rd_d;
  logic [31:0] ref_mem [256];
  logic        ref_ok  [256];
  logic        last_c, last_d;

  // Optional directed expectations for one cycle
  logic dir_en, dir_gc, dir_gd, dir_rc_en, dir_rc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic rst, input logic creq, input logic cwr,
                        input logic [31:0] caddr, input logic [31:0] cwd,
                        input logic dreq, input logic dwr,
                        input logic [31:0] daddr, input logic [31:0] dwd);
    s_rst = rst; s_creq = creq; s_cwr = cwr; s_caddr = caddr; s_cwd = cwd;
    s_dreq = dreq; s_dwr = dwr; s_daddr = daddr; s_dwd = dwd;
  endtask

  task automatic run_cycle();
    logic        exp_c, exp_d, exp_wr;
    logic [31:0] exp_addr, exp_wd;
    reset         = s_rst;
    bus.cpu_req   = s_creq;  bus.cpu_wr = s_cwr;  bus.cpu_addr = s_caddr;  bus.cpu_wdata = s_cwd;
    bus.dma_req   = s_dreq;  bus.dma_wr = s_dwr;  bus.dma_addr = s_daddr;  bus.dma_wdata = s_dwd;
    #2;
    exp_c = 1'b0;
    exp_d = 1'b0;
    if (!s_rst) begin
      if (m_run > 0 && s_dreq)    exp_d = 1'b1;
      else if (s_creq && s_dreq)  begin
        if (m_wait >= int'(STARVE_LIM)) exp_d = 1'b1;
        else                            exp_c = 1'b1;
      end
      else if (s_creq)            exp_c = 1'b1;
      else if (s_dreq)            exp_d = 1'b1;
    end
    exp_addr = exp_d ? s_daddr : s_caddr;
    exp_wd   = exp_d ? s_dwd   : s_cwd;
    exp_wr   = exp_d ? s_dwr   : (exp_c ? s_cwr : 1'b0);

    chk("cpu_gnt",    32'(bus.cpu_gnt),    32'(exp_c));
    chk("dma_gnt",    32'(bus.dma_gnt),    32'(exp_d));
    chk("mem_addr",   bus.mem_addr,        exp_addr);
    chk("mem_wdata",  bus.mem_wdata,       exp_wd);
    chk("mem_wr",     32'(bus.mem_wr),     32'(exp_wr));
    chk("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(m_rv_c && !s_rst));
    chk("dma_rvalid", 32'(bus.dma_rvalid), 32'(m_rv_d && !s_rst));
    if (m_rv_c && !s_rst && m_ok_c) chk("cpu_rdata", bus.cpu_rdata, m_rd_c);
    if (m_rv_d && !s_rst && m_ok_d) chk("dma_rdata", bus.dma_rdata, m_rd_d);
    if (dir_en) begin
      chk("dir_cpu_gnt", 32'(bus.cpu_gnt), 32'(dir_gc));
      chk("dir_dma_gnt", 32'(bus.dma_gnt), 32'(dir_gd));
      if (dir_rc_en) chk("dir_cpu_rvalid", 32'(bus.cpu_rvalid), 32'(dir_rc));
    end
    dir_en = 1'b0; dir_rc_en = 1'b0;

    last_c = exp_c;
    last_d = exp_d;
    if (s_rst) begin
      m_run = 0; m_wait = 0; m_rv_c = 1'b0; m_rv_d = 1'b0;
    end else begin
      m_rv_c = exp_c && !s_cwr;
      m_rv_d = exp_d && !s_dwr;
      if (m_rv_c) begin m_rd_c = ref_mem[s_caddr[9:2]]; m_ok_c = ref_ok[s_caddr[9:2]]; end
      if (m_rv_d) begin m_rd_d = ref_mem[s_daddr[9:2]]; m_ok_d = ref_ok[s_daddr[9:2]]; end
      if (exp_wr) begin
        ref_mem[exp_addr[9:2]] = exp_wd;
        ref_ok[exp_addr[9:2]]  = 1'b1;
      end
      if (exp_d || !s_dreq) m_wait = 0;
      else if (m_wait < int'(STARVE_LIM)) m_wait++;
      if (!s_dreq) m_run = 0;
      else if (exp_d && s_creq) begin
        m_run++;
        if (m_run == int'(DMA_MAX_BURST)) m_run = 0;
      end
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic step_dir(input logic gc, input logic gd);
    dir_en = 1'b1; dir_gc = gc; dir_gd = gd;
    run_cycle();
  endtask

  task automatic idle();
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    run_cycle();
  endtask

  initial begin
    logic [10:0] pat31;
    logic [8:0]  pat33;
    for (int i = 0; i < 256; i++) begin ref_mem[i] = '0; ref_ok[i] = 1'b0; end
    m_run = 0; m_wait = 0; m_rv_c = 1'b0; m_rv_d = 1'b0; m_ok_c = 1'b0; m_ok_d = 1'b0;
    m_rd_c = '0; m_rd_d = '0; last_c = 1'b0; last_d = 1'b0;
    dir_en = 1'b0; dir_gc = 1'b0; dir_gd = 1'b0; dir_rc_en = 1'b0; dir_rc = 1'b0;

    // Reset with both requesting: no grants, no write
    set_in(1'b1, 1'b1, 1'b1, 32'h40, 32'h1111, 1'b1, 1'b1, 32'h80, 32'h2222);
    step_dir(1'b0, 1'b0);
    step_dir(1'b0, 1'b0);

    // CPU write then read of 0x40; read returns written data one cycle later
    set_in(1'b0, 1'b1, 1'b1, 32'h40, 32'hA5A5_5A5A, 1'b0, 1'b0, 32'h0, 32'h0);
    step_dir(1'b1, 1'b0);
    set_in(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step_dir(1'b1, 1'b0);
    idle();

    // Sustained contention: CCC DDDD CCC D
    pat31 = 11'b100_0111_1000;
    for (int i = 0; i < 11; i++) begin
      set_in(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 32'h80 + 32'(4 * i), 32'h0);
      step_dir(!pat31[i], pat31[i]);
    end
    idle();

    // DMA-only writes 0x100..0x10C
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h100 + 32'(4 * i), 32'hD000_0000 + 32'(i));
      step_dir(1'b0, 1'b1);
    end
    idle();

    // Forced DMA at t3, dma_req drops at t4: CPU at t4, starvation count restarts
    pat33 = 9'b1_0000_1000;
    for (int i = 0; i < 9; i++) begin
      set_in(1'b0, 1'b1, 1'b0, 32'h44, 32'h0, (i != 4), 1'b0, 32'h104, 32'h0);
      step_dir(!pat33[i], pat33[i]);
    end
    idle();

    // CPU read, then reset: no rvalid, no grants during reset, grant right after
    set_in(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step_dir(1'b1, 1'b0);
    set_in(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b1, 32'h108, 32'h77);
    dir_rc_en = 1'b1; dir_rc = 1'b0;
    step_dir(1'b0, 1'b0);
    dir_rc_en = 1'b1; dir_rc = 1'b0;
    step_dir(1'b0, 1'b0);
    set_in(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b1, 32'h108, 32'h77);
    step_dir(1'b1, 1'b0);
    idle();

    // Randomized traffic; requesters hold their request until granted
    for (int n = 0; n < 800; n++) begin
      if (!s_creq || last_c) begin
        s_creq  = ($urandom_range(0, 3) != 0);
        s_cwr   = 1'($urandom_range(0, 1));
        s_caddr = {22'h0, 8'($urandom_range(0, 63)), 2'b00};
        s_cwd   = $urandom;
      end
      if (!s_dreq || last_d) begin
        s_dreq  = ($urandom_range(0, 3) != 0);
        s_dwr   = 1'($urandom_range(0, 1));
        s_daddr = {22'h0, 8'($urandom_range(0, 63)), 2'b00};
        s_dwd   = $urandom;
      end
      s_rst = ($urandom_range(0, 59) == 0);
      run_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
